hv_unbinder: RTL and testbench

//  Inverse of the binder permutation: recovers a level/item hypervector from a bound
//  (right-rotated) hypervector by rotating it LEFT by SHIFT positions, shift_cnt times.

---
 rtl/hv_unbinder.sv | 129 ++++++++++++
 tb/tb_hv_unbinder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hv_unbinder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hv_unbinder                                                    |
// | Purpose : Undo the binder permutation by rotating a hypervector left     |
// |           SHIFT bits per step, shift_cnt times (saturated to MAX_SHIFT). |
// | Config  : UNBINDER_BARREL_EN selects single-cycle barrel rotation;       |
// |           undefined gives iterative one-step-per-cycle rotation.         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module hv_unbinder #(
  parameter int HV_DIM    = 1024,
  parameter int SHIFT     = 1,
  parameter int MAX_SHIFT = 15,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] bound_hv,
  input  logic [CNT_W-1:0]  shift_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] unbound_hv,
  output logic              busy
);

  localparam logic [1:0]       c_IDLE    = 2'd0;
  localparam logic [1:0]       c_ROTATE  = 2'd1;
  localparam logic [1:0]       c_DONE    = 2'd2;
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [HV_DIM-1:0] r_hv;
  logic [HV_DIM-1:0] w_load_hv;
  logic [CNT_W-1:0]  w_cnt_sat;

  // Saturate before loading so the counter never sees an out-of-range value.
  assign w_cnt_sat = (shift_cnt > c_MAX_CNT) ? c_MAX_CNT : shift_cnt;

`ifdef UNBINDER_BARREL_EN
  logic [31:0]         w_amt;
  logic [2*HV_DIM-1:0] w_dbl;

  // Left-shifting a doubled copy leaves the rotated word in the upper half.
  assign w_amt     = (32'(w_cnt_sat) * 32'(SHIFT)) % 32'(HV_DIM);
  assign w_dbl     = {bound_hv, bound_hv} << w_amt;
  assign w_load_hv = w_dbl[2*HV_DIM-1:HV_DIM];
`else
  logic [CNT_W-1:0]  r_count;
  logic [HV_DIM-1:0] w_step_hv;

  assign w_step_hv = {r_hv[HV_DIM-SHIFT-1:0], r_hv[HV_DIM-1:HV_DIM-SHIFT]};
  assign w_load_hv = bound_hv;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else if (en) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (in_valid) begin
`ifdef UNBINDER_BARREL_EN
          w_next_state = c_DONE;
`else
          w_next_state = (w_cnt_sat == '0) ? c_DONE : c_ROTATE;
`endif
        end
      end
      c_ROTATE: begin
`ifdef UNBINDER_BARREL_EN
        w_next_state = c_IDLE;
`else
        if (r_count == c_ONE) begin
          w_next_state = c_DONE;
        end
`endif
      end
      c_DONE: begin
        if (out_ready) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = en && (r_state == c_IDLE);
    out_valid = (r_state == c_DONE);
    busy      = (r_state == c_ROTATE) || (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv    <= '0;
`ifndef UNBINDER_BARREL_EN
      r_count <= '0;
`endif
    end else if (en) begin
      if ((r_state == c_IDLE) && in_valid) begin
        r_hv    <= w_load_hv;
`ifndef UNBINDER_BARREL_EN
        r_count <= w_cnt_sat;
`endif
      end
`ifndef UNBINDER_BARREL_EN
      else if (r_state == c_ROTATE) begin
        r_hv    <= w_step_hv;
        r_count <= r_count - c_ONE;
      end
`endif
    end
  end

  assign unbound_hv = r_hv;

endmodule
`default_nettype wire

// File: tb/tb_hv_unbinder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_hv_unbinder                                                 |
// | Purpose : Self-checking bench for hv_unbinder against a rotation model.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_hv_unbinder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] bound_hv;
  logic [3:0] shift_cnt;
  int         sel;
  logic [2:0] iv;
  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [7:0] uh [3];

  int n_total = 0;
  int n_bad   = 0;

  int maxs [3] = '{15, 3, 15};
  int shf  [3] = '{1, 1, 3};

  always #5 clk = ~clk;

  always_comb iv = in_valid ? (3'b001 << sel) : 3'b000;

  hv_unbinder #(.HV_DIM(8), .SHIFT(1), .MAX_SHIFT(15), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[0]), .in_ready(ir[0]),
    .bound_hv(bound_hv), .shift_cnt(shift_cnt), .out_valid(ov[0]),
    .out_ready(out_ready), .unbound_hv(uh[0]), .busy(bz[0]));

  hv_unbinder #(.HV_DIM(8), .SHIFT(1), .MAX_SHIFT(3), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[1]), .in_ready(ir[1]),
    .bound_hv(bound_hv), .shift_cnt(shift_cnt[2:0]), .out_valid(ov[1]),
    .out_ready(out_ready), .unbound_hv(uh[1]), .busy(bz[1]));

  hv_unbinder #(.HV_DIM(8), .SHIFT(3), .MAX_SHIFT(15), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[2]), .in_ready(ir[2]),
    .bound_hv(bound_hv), .shift_cnt(shift_cnt), .out_valid(ov[2]),
    .out_ready(out_ready), .unbound_hv(uh[2]), .busy(bz[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Rotate left: bit i of the input lands at position (i + amount) mod 8.
  function automatic logic [7:0] ref_unbind(input logic [7:0] hv, input int cnt,
                                            input int mx, input int sh);
    int         n;
    int         a;
    logic [7:0] r;
    n = (cnt > mx) ? mx : cnt;
    a = (n * sh) % 8;
    r = '0;
    for (int i = 0; i < 8; i++) r[(i + a) % 8] = hv[i];
    return r;
  endfunction

  function automatic int ref_lat(input int sat);
`ifdef UNBINDER_BARREL_EN
    return (sat >= 0) ? 1 : 1;
`else
    return sat + 1;
`endif
  endfunction

  // Out_ready held high: checks latency, data and the in_ready gap cycle by cycle.
  task automatic pipe(input int cnt, input logic [7:0] hv, input logic [7:0] exp);
    int el;
    sel       = 0;
    el        = ref_lat((cnt > 15) ? 15 : cnt);
    en        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bound_hv  = hv;
    shift_cnt = 4'(cnt);
    check("pipe_rdy_idle", 32'(ir[0]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    bound_hv = 8'($urandom);
    for (int c = 1; c <= el; c++) begin
      check("pipe_rdy_busy", 32'(ir[0]), 32'd0);
      check("pipe_out_valid", 32'(ov[0]), (c == el) ? 32'd1 : 32'd0);
      if (c == el) check("pipe_data", 32'(uh[0]), 32'(exp));
      @(negedge clk);
    end
    check("pipe_rdy_after", 32'(ir[0]), 32'd1);
    check("pipe_ov_after", 32'(ov[0]), 32'd0);
    out_ready = 1'b0;
  endtask

  // One request on instance s with optional enable stalls and DONE backpressure.
  task automatic txn(input int s, input int cnt, input logic [7:0] hv,
                     input bit stall, input int hold);
    logic [7:0] exp;
    int         ec;
    int         sat;
    int         lat;
    int         stalls;
    sel       = s;
    ec        = (s == 1) ? (cnt & 7) : cnt;
    sat       = (ec > maxs[s]) ? maxs[s] : ec;
    exp       = ref_unbind(hv, ec, maxs[s], shf[s]);
    en        = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    bound_hv  = hv;
    shift_cnt = 4'(cnt);
    check("txn_rdy_idle", 32'(ir[s]), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    bound_hv  = 8'($urandom);
    shift_cnt = 4'($urandom);
    lat       = 1;
    stalls    = 0;
    while (!ov[s] && lat < 100) begin
      check("txn_rdy_busy", 32'(ir[s]), 32'd0);
      check("txn_busy", 32'(bz[s]), 32'd1);
      in_valid = 1'($urandom);
      en       = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!en) stalls++;
      @(negedge clk);
      lat++;
    end
    check("txn_latency", 32'(lat), 32'(ref_lat(sat) + stalls));
    check("txn_data", 32'(uh[s]), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      en        = 1'($urandom);
      out_ready = en ? 1'b0 : 1'($urandom);
      in_valid  = 1'($urandom);
      bound_hv  = 8'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(ov[s]), 32'd1);
      check("hold_data", 32'(uh[s]), 32'(exp));
      check("hold_rdy", 32'(ir[s]), 32'd0);
    end
    en        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(ov[s]), 32'd0);
    check("release_rdy", 32'(ir[s]), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    sel       = 0;
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bound_hv  = '0;
    shift_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_hv", 32'(uh[k]), 32'd0);
      check("reset_ov", 32'(ov[k]), 32'd0);
      check("reset_busy", 32'(bz[k]), 32'd0);
      check("reset_rdy", 32'(ir[k]), 32'd1);
    end

    // Disabled block must neither advertise ready nor accept.
    en       = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("en0_rdy", 32'(ir[0]), 32'd0);
    check("en0_busy", 32'(bz[0]), 32'd0);
    in_valid = 1'b0;
    en       = 1'b1;
    @(negedge clk);

    pipe(3, 8'h01, 8'h08);
    pipe(1, 8'hC1, 8'h83);
    pipe(0, 8'hC1, 8'hC1);
    pipe(8, 8'h5A, 8'h5A);
    pipe(5, 8'h81, 8'h30);
    pipe(15, 8'h01, 8'h80);

    txn(0, 2, 8'h3C, 1'b0, 5);
    txn(0, 5, 8'h96, 1'b1, 2);
    txn(1, 7, 8'h01, 1'b0, 1);
    txn(2, 3, 8'h01, 1'b0, 1);

    // Reset in the middle of a rotation discards the request.
    sel       = 0;
    en        = 1'b1;
    in_valid  = 1'b1;
    bound_hv  = 8'hA5;
    shift_cnt = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ov", 32'(ov[0]), 32'd0);
    check("midrst_hv", 32'(uh[0]), 32'd0);
    check("midrst_rdy", 32'(ir[0]), 32'd1);
    check("midrst_busy", 32'(bz[0]), 32'd0);
    pipe(2, 8'h11, 8'h44);

    for (int t = 0; t < 60; t++) begin
      txn($urandom_range(0, 2), $urandom_range(0, 15), 8'($urandom),
          1'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
